// File: rtl/rf_write_buffer_pkg.sv
// Shared definitions for the register-file write buffer.
// RF_WBUF_DEPTH sets the default queue depth (power of two, >= 2).
// RF_WBUF_FWD_EN (optional) adds the decode-side forwarding lookup ports.
`ifndef RF_WBUF_DEPTH
`define RF_WBUF_DEPTH 4
`endif

package rf_write_buffer_pkg;

    localparam int unsigned DEF_DEPTH      = `RF_WBUF_DEPTH;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 5;

    // Queue activity on a given edge: bit0 = enqueue, bit1 = dequeue.
    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } buf_op_e;

    function automatic buf_op_e buf_op(input logic push, input logic pop);
        return buf_op_e'({pop, push});
    endfunction

endpackage

// File: rtl/rf_wbuf_match.sv
// Forwarding lookup over the write-buffer storage: reports whether any valid
// entry targets lookup_addr_i and returns the youngest (closest to tail) data.
// Only built when RF_WBUF_FWD_EN is defined; the default build has no lookup.
`ifdef RF_WBUF_FWD_EN
module rf_wbuf_match #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned PTR_W      = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] entry_addr_i,
    input  logic [DEPTH-1:0][DATA_WIDTH-1:0] entry_data_i,
    input  logic [DEPTH-1:0]                 valid_i,
    input  logic [PTR_W-1:0]                 head_i,
    input  logic [ADDR_WIDTH-1:0]            lookup_addr_i,
    output logic                             hit_o,
    output logic [DATA_WIDTH-1:0]            data_o
);

    logic [PTR_W-1:0] idx;

    // Walk from oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            idx = head_i + PTR_W'(k);
            if (valid_i[idx] && (entry_addr_i[idx] == lookup_addr_i) &&
                (lookup_addr_i != '0)) begin
                hit_o  = 1'b1;
                data_o = entry_data_i[idx];
            end
        end
    end

endmodule
`endif

// File: rtl/rf_write_buffer.sv
// In-order writeback queue in front of the 32x32 register file write port.
// Drains one entry per cycle, holding off while decode reads the file.
// Writes to register 0 complete the handshake but are dropped.
// Optional: RF_WBUF_FWD_EN adds two forwarding lookups (fwd_*) for decode.
module rf_write_buffer
    import rf_write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [ADDR_WIDTH-1:0]      in_addr_i,
    input  logic [DATA_WIDTH-1:0]      in_data_i,
    input  logic                       rf_read_i,
    output logic                       rf_write_o,
    output logic [ADDR_WIDTH-1:0]      rf_addr_w_o,
    output logic [DATA_WIDTH-1:0]      rf_data_w_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o,
    output logic                       full_o
`ifdef RF_WBUF_FWD_EN
    ,
    input  logic [ADDR_WIDTH-1:0]      fwd_addr1_i,
    input  logic [ADDR_WIDTH-1:0]      fwd_addr2_i,
    output logic                       fwd_hit1_o,
    output logic                       fwd_hit2_o,
    output logic [DATA_WIDTH-1:0]      fwd_data1_o,
    output logic [DATA_WIDTH-1:0]      fwd_data2_o
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_q;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic    push;
    logic    enq;
    logic    pop;
    buf_op_e op;

    // Status comes from the occupancy count; head==tail is ambiguous.
    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CNT_FULL);
    assign count_o    = count_q;
    assign in_ready_o = !full_o;

    assign push = in_valid_i & in_ready_o;
    assign enq  = push & (in_addr_i != '0);

    assign rf_write_o  = !empty_o & !rf_read_i;
    assign rf_addr_w_o = empty_o ? '0 : addr_q[head_q];
    assign rf_data_w_o = empty_o ? '0 : data_q[head_q];
    assign pop         = rf_write_o;

    // Next pointers and occupancy; pointers wrap naturally at DEPTH.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        op      = buf_op(enq, pop);
        case (op)
            OP_PUSH: begin
                tail_d  = tail_q + PTR_ONE;
                count_d = count_q + CNT_ONE;
            end
            OP_POP: begin
                head_d  = head_q + PTR_ONE;
                count_d = count_q - CNT_ONE;
            end
            OP_BOTH: begin
                tail_d = tail_q + PTR_ONE;
                head_d = head_q + PTR_ONE;
            end
            default: ;
        endcase
    end

    // Pointer and count registers; reset empties the queue immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            addr_q[tail_q] <= in_addr_i;
            data_q[tail_q] <= in_data_i;
        end
    end

`ifdef RF_WBUF_FWD_EN
    logic [DEPTH-1:0] valid_mask;
    logic [PTR_W-1:0] age;

    // A slot is live when its distance from head is below the occupancy.
    always_comb begin
        valid_mask = '0;
        age        = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            age           = PTR_W'(i) - head_q;
            valid_mask[i] = (CNT_W'(age) < count_q);
        end
    end

    rf_wbuf_match #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_match1 (
        .entry_addr_i  (addr_q),
        .entry_data_i  (data_q),
        .valid_i       (valid_mask),
        .head_i        (head_q),
        .lookup_addr_i (fwd_addr1_i),
        .hit_o         (fwd_hit1_o),
        .data_o        (fwd_data1_o)
    );

    rf_wbuf_match #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_match2 (
        .entry_addr_i  (addr_q),
        .entry_data_i  (data_q),
        .valid_i       (valid_mask),
        .head_i        (head_q),
        .lookup_addr_i (fwd_addr2_i),
        .hit_o         (fwd_hit2_o),
        .data_o        (fwd_data2_o)
    );
`endif

endmodule

// File: tb/tb_rf_write_buffer.sv
// Self-checking bench for rf_write_buffer: a queue-based model is compared
// against the DUT every cycle, plus directed scenarios with literal values.
module tb_rf_write_buffer;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] in_addr = '0;
    logic [DW-1:0] in_data = '0;
    logic          rf_read = 1'b0;
    logic          rf_write;
    logic [AW-1:0] rf_addr_w;
    logic [DW-1:0] rf_data_w;
    logic [2:0]    count;
    logic          empty;
    logic          full;
`ifdef RF_WBUF_FWD_EN
    logic [AW-1:0] fwd_addr1 = '0;
    logic [AW-1:0] fwd_addr2 = '0;
    logic          fwd_hit1, fwd_hit2;
    logic [DW-1:0] fwd_data1, fwd_data2;
`endif

    rf_write_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_addr_i   (in_addr),
        .in_data_i   (in_data),
        .rf_read_i   (rf_read),
        .rf_write_o  (rf_write),
        .rf_addr_w_o (rf_addr_w),
        .rf_data_w_o (rf_data_w),
        .count_o     (count),
        .empty_o     (empty),
        .full_o      (full)
`ifdef RF_WBUF_FWD_EN
        ,
        .fwd_addr1_i (fwd_addr1),
        .fwd_addr2_i (fwd_addr2),
        .fwd_hit1_o  (fwd_hit1),
        .fwd_hit2_o  (fwd_hit2),
        .fwd_data1_o (fwd_data1),
        .fwd_data2_o (fwd_data2)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          mq[$];
    logic [DW-1:0] rf_model [32];
    int            n_pass  = 0;
    int            n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic void model_fwd(input logic [AW-1:0] a, output logic hit, output logic [DW-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (a != '0) begin
            foreach (mq[i]) begin
                if (mq[i].a == a) begin
                    hit = 1'b1;
                    d   = mq[i].d;
                end
            end
        end
    endfunction

    // Model compare on the falling edge, then advance the model to the next rising edge.
    logic          m_write;
    logic          m_can_push;
    logic          m_hit;
    logic [DW-1:0] m_fd;
    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            check("rst_count", 32'(count), 0);
            check("rst_empty", 32'(empty), 1);
            check("rst_full", 32'(full), 0);
            check("rst_ready", 32'(in_ready), 1);
            check("rst_write", 32'(rf_write), 0);
            check("rst_addr", 32'(rf_addr_w), 0);
            check("rst_data", rf_data_w, 0);
        end else begin
            m_write    = (mq.size() > 0) && !rf_read;
            m_can_push = (mq.size() < DEPTH);
            check("m_count", 32'(count), 32'(mq.size()));
            check("m_empty", 32'(empty), 32'(mq.size() == 0));
            check("m_full", 32'(full), 32'(mq.size() == DEPTH));
            check("m_ready", 32'(in_ready), 32'(m_can_push));
            check("m_write", 32'(rf_write), 32'(m_write));
            check("m_addr", 32'(rf_addr_w), (mq.size() > 0) ? 32'(mq[0].a) : 0);
            check("m_data", rf_data_w, (mq.size() > 0) ? mq[0].d : 0);
`ifdef RF_WBUF_FWD_EN
            model_fwd(fwd_addr1, m_hit, m_fd);
            check("m_hit1", 32'(fwd_hit1), 32'(m_hit));
            check("m_fdata1", fwd_data1, m_fd);
            model_fwd(fwd_addr2, m_hit, m_fd);
            check("m_hit2", 32'(fwd_hit2), 32'(m_hit));
            check("m_fdata2", fwd_data2, m_fd);
`endif
            if (m_write) begin
                rf_model[mq[0].a] = mq[0].d;
                void'(mq.pop_front());
            end
            if (in_valid && m_can_push && (in_addr != '0))
                mq.push_back('{a: in_addr, d: in_data});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        foreach (rf_model[i]) rf_model[i] = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("init_empty", 32'(empty), 1);

        // Single write: visible on the RF port the cycle after the push.
        push(5'd5, 32'hDEADBEEF);
        #1;
        check("sw_write", 32'(rf_write), 1);
        check("sw_addr", 32'(rf_addr_w), 5);
        check("sw_data", rf_data_w, 32'hDEADBEEF);
        step();
        check("sw_reg5", rf_model[5], 32'hDEADBEEF);
        check("sw_empty", 32'(empty), 1);

        // Fill while decode reads, then drain in order.
        rf_read = 1'b1;
        for (int i = 0; i < 4; i++) push(5'(i + 1), 32'hA0 + 32'(i));
        #1;
        check("fill_full", 32'(full), 1);
        check("fill_ready", 32'(in_ready), 0);
        check("fill_count", 32'(count), 4);
        push(5'd20, 32'h55);
        #1;
        check("fill_nopush", 32'(count), 4);
        rf_read = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("drain_write", 32'(rf_write), 1);
            check("drain_addr", 32'(rf_addr_w), 32'(i + 1));
            check("drain_data", rf_data_w, 32'hA0 + 32'(i));
            step();
        end
        check("drain_empty", 32'(empty), 1);
        check("drain_reg3", rf_model[3], 32'hA2);

        // Register 0 request completes but is discarded.
        in_valid = 1'b1;
        in_addr  = '0;
        in_data  = 32'h1234;
        #1;
        check("zero_ready", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        #1;
        check("zero_count", 32'(count), 0);
        check("zero_write", 32'(rf_write), 0);

        // Push and pop on the same edge at COUNT=2 with tail wrapping 3->0.
        rf_read = 1'b1;
        push(5'd8, 32'h88);
        push(5'd9, 32'h99);
        rf_read  = 1'b0;
        in_valid = 1'b1;
        in_addr  = 5'd10;
        in_data  = 32'hAA;
        #1;
        check("pp_addr0", 32'(rf_addr_w), 8);
        step();
        in_valid = 1'b0;
        #1;
        check("pp_count", 32'(count), 2);
        check("pp_addr1", 32'(rf_addr_w), 9);
        step();
        check("pp_addr2", 32'(rf_addr_w), 10);
        check("pp_data2", rf_data_w, 32'hAA);
        step();
        check("pp_empty", 32'(empty), 1);

        // Two pending writes to r7, then a third entry for the reset test.
        rf_read = 1'b1;
        push(5'd7, 32'h1);
        push(5'd7, 32'h2);
`ifdef RF_WBUF_FWD_EN
        fwd_addr1 = 5'd7;
        fwd_addr2 = 5'd0;
        #1;
        check("fwd_hit1", 32'(fwd_hit1), 1);
        check("fwd_data1", fwd_data1, 32'h2);
        check("fwd_hit2", 32'(fwd_hit2), 0);
        check("fwd_data2", fwd_data2, 0);
`endif
        push(5'd11, 32'h3);
        #1;
        check("rst_pre_count", 32'(count), 3);

        // Asynchronous reset mid-traffic clears the queue at once.
        in_valid = 1'b1;
        in_addr  = 5'd12;
        in_data  = 32'h4;
        #1 rst_n = 1'b0;
        #1;
        check("arst_count", 32'(count), 0);
        check("arst_empty", 32'(empty), 1);
        check("arst_write", 32'(rf_write), 0);
        step();
        step();
        in_valid = 1'b0;
        rf_read  = 1'b0;
        rst_n    = 1'b1;
        #1;
        check("arst_after", 32'(empty), 1);

        // Mixed traffic pattern, checked by the model every cycle.
        for (int c = 0; c < 40; c++) begin
            in_valid = ((c % 3) != 2);
            in_addr  = 5'((c * 7) % 32);
            in_data  = 32'(c) * 32'h01010101;
            rf_read  = ((c % 5) == 1) || ((c % 7) == 3);
`ifdef RF_WBUF_FWD_EN
            fwd_addr1 = 5'((c * 3) % 32);
            fwd_addr2 = 5'(c % 8);
`endif
            step();
        end
        in_valid = 1'b0;
        rf_read  = 1'b0;
        repeat (6) step();
        check("mix_empty", 32'(empty), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
